// File: rtl/seq_pkg.sv
// Shared types for the note sequencer: FSM states, duration classes and the
// code-to-class mapping used by the duration decoder.
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StGap,
        StPlay,
        StPaused,
        StDone
    } seq_state_t;

    typedef enum logic [1:0] {
        DUR4,
        DUR8,
        DUR16
    } dur_class_t;

    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] TEMPO_SLOW = 2'd1;
    localparam logic [1:0] TEMPO_FAST = 2'd2;

    // Codes come in banks of quarter/eighth/sixteenth ranges, repeated per octave.
    function automatic dur_class_t dur_class(input logic [5:0] code);
        dur_class_t cls;
        if (code <= 6'd7) begin
            cls = DUR8;
        end else if (code <= 6'd14) begin
            cls = DUR4;
        end else if (code <= 6'd21) begin
            cls = DUR16;
        end else if (code <= 6'd28) begin
            cls = DUR8;
        end else if (code <= 6'd35) begin
            cls = DUR4;
        end else if (code <= 6'd42) begin
            cls = DUR16;
        end else if (code <= 6'd49) begin
            cls = DUR8;
        end else if (code <= 6'd56) begin
            cls = DUR4;
        end else begin
            cls = DUR16;
        end
        return cls;
    endfunction

endpackage

// File: rtl/note_duration_decode.sv
// Combinational decode of a note code (and tempo setting) into the number of
// cycles the note sounds for.
module note_duration_decode
    import seq_pkg::*;
#(
    parameter int unsigned T4_CYC  = 50_000_000,
    parameter int unsigned T8_CYC  = 25_000_000,
    parameter int unsigned T16_CYC = 12_500_000
) (
    input  logic [5:0]       i_code,
    input  logic [1:0]       i_tempo,
    output logic [CNT_W-1:0] o_cycles
);

    logic [CNT_W-1:0] w_base;

    always_comb begin
        w_base = CNT_W'(T8_CYC);
        case (dur_class(i_code))
            DUR4:    w_base = CNT_W'(T4_CYC);
            DUR8:    w_base = CNT_W'(T8_CYC);
            DUR16:   w_base = CNT_W'(T16_CYC);
            default: w_base = CNT_W'(T8_CYC);
        endcase
    end

    always_comb begin
        o_cycles = w_base;
        if (i_tempo == TEMPO_SLOW) begin
            o_cycles = w_base << 1;
        end else if (i_tempo == TEMPO_FAST) begin
            o_cycles = w_base >> 1;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Song playback sequencer: fetches note codes from the ROM, times gap and sounding
// intervals, and drives note_code/note_on. Define SEQ_TEMPO_EN to add the tempo port.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned T4_CYC  = 50_000_000,
    parameter int unsigned T8_CYC  = 25_000_000,
    parameter int unsigned T16_CYC = 12_500_000,
    parameter int unsigned GAP_CYC = 5_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic [1:0]        song_sel,
    input  logic [ADDR_W-3:0] song_len,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_valid,
    input  logic [5:0]        rom_code,
    output logic [5:0]        note_code,
    output logic              note_on,
    output logic [ADDR_W-3:0] index,
    output logic              busy,
    output logic              done
`ifdef SEQ_TEMPO_EN
    ,
    input  logic [1:0]        tempo
`endif
);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    seq_state_t        r_state, w_state_nxt;
    seq_state_t        r_ret, w_ret_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [1:0]        r_sel, w_sel_nxt;
    logic [ADDR_W-3:0] r_len, w_len_nxt;
    logic [ADDR_W-3:0] r_index, w_index_nxt;
    logic [5:0]        r_code, w_code_nxt;
    logic [1:0]        r_tempo, w_tempo_nxt;
    logic              r_done, w_done_nxt;

    logic [1:0]        w_tempo_in;
    logic [CNT_W-1:0]  w_play_cyc;
    logic [CNT_W-1:0]  w_play_last;
    logic [ADDR_W-3:0] w_index_inc;

`ifdef SEQ_TEMPO_EN
    assign w_tempo_in = tempo;
`else
    assign w_tempo_in = 2'b00;
`endif

    note_duration_decode #(
        .T4_CYC  (T4_CYC),
        .T8_CYC  (T8_CYC),
        .T16_CYC (T16_CYC)
    ) u_dur (
        .i_code   (r_code),
        .i_tempo  (r_tempo),
        .o_cycles (w_play_cyc)
    );

    assign w_play_last = w_play_cyc - CNT_W'(1);
    assign w_index_inc = r_index + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_ret   <= StGap;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_len   <= '0;
            r_index <= '0;
            r_code  <= '0;
            r_tempo <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_len   <= w_len_nxt;
            r_index <= w_index_nxt;
            r_code  <= w_code_nxt;
            r_tempo <= w_tempo_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_len_nxt   = r_len;
        w_index_nxt = r_index;
        w_code_nxt  = r_code;
        w_tempo_nxt = r_tempo;
        w_done_nxt  = 1'b0;

        if (stop) begin
            // Abort returns every output-visible register to its reset value.
            w_state_nxt = StIdle;
            w_ret_nxt   = StGap;
            w_cnt_nxt   = '0;
            w_sel_nxt   = '0;
            w_len_nxt   = '0;
            w_index_nxt = '0;
            w_code_nxt  = '0;
            w_tempo_nxt = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        w_sel_nxt   = song_sel;
                        w_len_nxt   = song_len;
                        w_index_nxt = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = (song_len == '0) ? StDone : StFetch;
                    end
                end
                StFetch: begin
                    w_state_nxt = StWait;
                end
                StWait: begin
                    if (rom_valid) begin
                        w_code_nxt  = rom_code;
                        w_cnt_nxt   = '0;
                        w_state_nxt = StGap;
                    end
                end
                StGap: begin
                    if (r_cnt == GAP_LAST) begin
                        w_cnt_nxt   = '0;
                        w_tempo_nxt = w_tempo_in;
                        w_state_nxt = StPlay;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (pause) begin
                            w_ret_nxt   = StGap;
                            w_state_nxt = StPaused;
                        end
                    end
                end
                StPlay: begin
                    // The cycle in which pause is seen still counts; the note never
                    // loses or gains sounding cycles across a pause.
                    if (r_cnt == w_play_last) begin
                        w_cnt_nxt = '0;
                        if (w_index_inc == r_len) begin
                            w_state_nxt = StDone;
                        end else begin
                            w_index_nxt = w_index_inc;
                            w_state_nxt = StFetch;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (pause) begin
                            w_ret_nxt   = StPlay;
                            w_state_nxt = StPaused;
                        end
                    end
                end
                StPaused: begin
                    if (!pause) begin
                        w_state_nxt = r_ret;
                    end
                end
                StDone: begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StIdle;
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    assign rom_req   = (r_state == StFetch);
    assign rom_addr  = {r_sel, r_index};
    assign note_code = r_code;
    assign note_on   = (r_state == StPlay) && (r_code != 6'd0);
    assign index     = r_index;
    assign busy      = (r_state != StIdle);
    assign done      = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: ROM responder with random latency,
// song-level reference model, directed pause/stop/empty-song cases.
module tb_note_sequencer;

    localparam int unsigned ADDR_W = 14;
    localparam int T4  = 8;
    localparam int T8  = 4;
    localparam int T16 = 2;
    localparam int GAP = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              stop = 1'b0;
    logic [1:0]        song_sel = '0;
    logic [ADDR_W-3:0] song_len = '0;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_valid = 1'b0;
    logic [5:0]        rom_code = '0;
    logic [5:0]        note_code;
    logic              note_on;
    logic [ADDR_W-3:0] index;
    logic              busy;
    logic              done;
    int                cur_tempo = 0;
`ifdef SEQ_TEMPO_EN
    logic [1:0]        tempo;
    always_comb tempo = cur_tempo[1:0];
`endif

    always #5 clk = ~clk;

    note_sequencer #(
        .ADDR_W  (ADDR_W),
        .T4_CYC  (T4),
        .T8_CYC  (T8),
        .T16_CYC (T16),
        .GAP_CYC (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .song_sel  (song_sel),
        .song_len  (song_len),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_valid (rom_valid),
        .rom_code  (rom_code),
        .note_code (note_code),
        .note_on   (note_on),
        .index     (index),
        .busy      (busy),
        .done      (done)
`ifdef SEQ_TEMPO_EN
        ,
        .tempo     (tempo)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Sounding cycles from the code table: code 0 and codes 1.. in banks of 7 cycle
    // through eighth, quarter, sixteenth.
    function automatic int exp_play(input int code, input int tmp);
        int grp;
        int base;
        grp  = (code == 0) ? 0 : ((code - 1) / 7) % 3;
        base = (grp == 0) ? T8 : (grp == 1) ? T4 : T16;
        if (tmp == 1) base = base * 2;
        else if (tmp == 2) base = base / 2;
        return base;
    endfunction

    // ROM responder
    logic [5:0]        rom_mem [0:(1<<ADDR_W)-1];
    int                fixed_lat = 0;
    bit                spur_en = 1'b0;
    bit                pending = 1'b0;
    int                lat_cnt = 0;
    int                lat = 0;
    logic [ADDR_W-1:0] req_addr = '0;
    int                lat_q[$];

    always @(negedge clk) begin
        rom_valid = 1'b0;
        rom_code  = 6'($urandom);
        if (reset) begin
            pending = 1'b0;
        end else if (pending) begin
            if (lat_cnt == 0) begin
                rom_valid = 1'b1;
                rom_code  = rom_mem[req_addr];
                pending   = 1'b0;
            end else begin
                lat_cnt--;
            end
        end else if (rom_req) begin
            lat      = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
            lat_q.push_back(lat);
            lat_cnt  = lat - 1;
            req_addr = rom_addr;
            pending  = 1'b1;
        end else if (spur_en && $urandom_range(0, 5) == 0) begin
            rom_valid = 1'b1;
        end
    end

    // Monitor
    bit   mon_en = 1'b0;
    int   busy_cnt, done_cnt, req_cnt, on_acc;
    int   on_q[$];
    int   addr_q[$];
    int   idx_q[$];
    int   cur_codes[$];
    int   cur_base;
    logic prev_on = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (req_cnt > 0) on_q.push_back(on_acc);
                on_acc = 0;
            end
            if (rom_req) begin
                if (req_cnt > 0) on_q.push_back(on_acc);
                on_acc = 0;
                addr_q.push_back(int'(rom_addr));
                idx_q.push_back(int'(index));
                req_cnt++;
            end
            if (note_on) begin
                on_acc++;
                if (!prev_on && req_cnt > 0 && req_cnt <= cur_codes.size())
                    chk("note_code", 32'(note_code), 32'(cur_codes[req_cnt-1]));
            end
        end
        prev_on = note_on;
    end

    task automatic start_song(input logic [1:0] sel, input int len);
        @(negedge clk);
        cur_base = int'(sel) << (ADDR_W - 2);
        for (int i = 0; i < len; i++) rom_mem[cur_base + i] = 6'(cur_codes[i]);
        busy_cnt = 0; done_cnt = 0; req_cnt = 0; on_acc = 0;
        on_q.delete(); addr_q.delete(); idx_q.delete(); lat_q.delete();
        mon_en   = 1'b1;
        song_sel = sel;
        song_len = (ADDR_W-2)'(len);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        song_sel = 2'($urandom);
        song_len = (ADDR_W-2)'($urandom);
    endtask

    task automatic finish_song(input int len, input int extra);
        int cyc = 0;
        int exp_busy = 1 + extra;
        while (done_cnt == 0 && cyc < 3000) begin
            @(negedge clk);
            start = busy && ($urandom_range(0, 15) == 0);
            cyc++;
        end
        start = 1'b0;
        chk("song_timeout", 32'(cyc < 3000), 32'd1);
        @(negedge clk);
        mon_en = 1'b0;
        chk("fetch_count", 32'(lat_q.size()), 32'(len));
        for (int i = 0; i < len; i++) begin
            if (i < lat_q.size()) exp_busy += 1 + lat_q[i] + GAP + exp_play(cur_codes[i], cur_tempo);
        end
        chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("addr_count", 32'(addr_q.size()), 32'(len));
        chk("on_count", 32'(on_q.size()), 32'(len));
        for (int i = 0; i < len && i < addr_q.size() && i < on_q.size(); i++) begin
            chk($sformatf("rom_addr[%0d]", i), 32'(addr_q[i]), 32'(cur_base + i));
            chk($sformatf("index[%0d]", i), 32'(idx_q[i]), 32'(i));
            chk($sformatf("note_on_cycles[%0d]", i), 32'(on_q[i]),
                32'((cur_codes[i] == 0) ? 0 : exp_play(cur_codes[i], cur_tempo)));
        end
    endtask

    task automatic run_song(input logic [1:0] sel);
        start_song(sel, cur_codes.size());
        finish_song(cur_codes.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int acc;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rom_req", 32'(rom_req), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_note_code", 32'(note_code), 32'd0);
        chk("rst_note_on", 32'(note_on), 32'd0);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Two-note song on song 2
        cur_codes = '{1, 8};
        run_song(2'd2);

        // Silent code 0 followed by other classes
        cur_codes = '{0, 15, 22};
        run_song(2'd1);

        // Random songs with stray rom_valid pulses
        spur_en = 1'b1;
        for (int s = 0; s < 6; s++) begin
            cur_codes.delete();
            for (int i = 0; i < int'($urandom_range(1, 5)); i++)
                cur_codes.push_back(int'($urandom_range(0, 63)));
`ifdef SEQ_TEMPO_EN
            cur_tempo = int'($urandom_range(0, 3));
`endif
            run_song(2'($urandom));
        end
        spur_en   = 1'b0;
        cur_tempo = 0;

        // Pause for 10 cycles after two sounding cycles
        cur_codes = '{8};
        fixed_lat = 1;
        start_song(2'd1, 1);
        cyc = 0;
        while (!note_on && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("pause_wait_on", 32'(note_on), 32'd1);
        @(negedge clk);
        chk("pause_pre_on", 32'(note_on), 32'd1);
        pause = 1'b1;
        acc = 0;
        repeat (10) begin
            @(negedge clk);
            acc += int'(note_on);
        end
        pause = 1'b0;
        chk("pause_quiet", 32'(acc), 32'd0);
        chk("pause_busy", 32'(busy), 32'd1);
        acc = 0;
        cyc = 0;
        do begin
            @(negedge clk);
            acc += int'(note_on);
            cyc++;
        end while (busy && cyc < 100);
        chk("pause_post_on", 32'(acc), 32'd6);
        finish_song(1, 10);

        // Stop while waiting for ROM data
        cur_codes = '{5, 5, 5};
        fixed_lat = 2;
        start_song(2'd3, 3);
        chk("stop_fetch_req", 32'(rom_req), 32'd1);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_rom_addr", 32'(rom_addr), 32'd0);
        chk("stop_note_code", 32'(note_code), 32'd0);
        chk("stop_note_on", 32'(note_on), 32'd0);
        chk("stop_rom_req", 32'(rom_req), 32'd0);
        repeat (20) @(negedge clk);
        chk("stop_req_count", 32'(req_cnt), 32'd1);
        chk("stop_no_done", 32'(done_cnt), 32'd0);
        chk("stop_idle_busy", 32'(busy), 32'd0);
        mon_en    = 1'b0;
        fixed_lat = 0;

        // Empty song
        cur_codes.delete();
        start_song(2'd1, 0);
        chk("empty_busy1", 32'(busy), 32'd1);
        chk("empty_done1", 32'(done), 32'd0);
        @(negedge clk);
        chk("empty_done2", 32'(done), 32'd1);
        chk("empty_busy2", 32'(busy), 32'd0);
        @(negedge clk);
        chk("empty_done3", 32'(done), 32'd0);
        chk("empty_no_req", 32'(req_cnt), 32'd0);
        chk("empty_done_count", 32'(done_cnt), 32'd1);
        mon_en = 1'b0;

`ifdef SEQ_TEMPO_EN
        for (int t = 1; t <= 3; t++) begin
            cur_tempo = t;
            cur_codes = '{8};
            run_song(2'd0);
        end
        cur_tempo = 0;
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
